dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
Direct-mapped, write-through, no-write-allocate data cache sitting directly below the MEM stage. It takes MEM's per-cycle read/write request, address and store data, and returns load data plus a hit flag. It tells the pipeline to stall on misses and stores. It owns the handshake to the backing word memory, including 4-word burst refill.

Parameters:
INDEX_BITS, 4, number of index bits; 16 lines
WORDS_PER_LINE, 4, words per line; fixed power of two
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
read_i  in  1  load request from MEM
write_i  in  1  store request from MEM; priority over read_i if both are high
address_i  in  32  byte address; bits [1:0] ignored
data_i  in  32  store data
data_o  out  32  load data; valid when hit_o=1 in IDLE; otherwise 0
hit_o  out  1  tag match and valid line for current address, evaluated in IDLE
stall_o  out  1  pipeline must hold request and inputs while high
mem_req_o  out  1  backing-memory request
mem_we_o  out  1  1=write, 0=read
mem_addr_o  out  32  word-aligned memory address
mem_wdata_o  out  32  memory write data
mem_rdata_i  in  32  memory read data; sampled on mem_ack_i
mem_ack_i  in  1  one-cycle completion strobe per word

Behaviour:
- Reset is synchronous, active-high, on clk.
- Address split: word offset [3:2], index [7:4], tag [31:8].
- Arrays: valid[16], tag[16], data[16][4].
- FSM states: IDLE, REFILL, WRITE. Reset sets state=IDLE, refill counter=0 and all valid bits=0.
- Outputs after reset: mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, stall_o=0, hit_o=0, data_o=0.
- IDLE, read hit: hit_o=1, data_o=word, stall_o=0, all combinational. Zero-cycle latency; no memory traffic.
- IDLE, read miss: stall_o=1 the same cycle. Next state REFILL, count=0. Latch miss tag and index.
- IDLE, write (hit or miss): stall_o=1. Next state WRITE. Latch address and data.
- REFILL:
  - mem_req_o=1, mem_we_o=0, mem_addr_o={tag,index,count,2'b00}, stall_o=1.
  - Each mem_ack_i writes mem_rdata_i into word[count], then count++.
  - Ack with count=3: set valid and tag, go to IDLE.
  - The read then hits in IDLE on the following cycle. Refill-to-data latency is last ack + 1 cycle.
- WRITE:
  - mem_req_o=1, mem_we_o=1, mem_addr_o={addr[31:2],2'b00}, mem_wdata_o=latched data. All held stable until ack.
  - stall_o=1 until the ack cycle. In the ack cycle stall_o=0 (combinational), so the store retires at that edge.
  - On ack: if the latched address hits, update that cached word; miss allocates nothing. Then go to IDLE.
- Memory protocol:
  - mem_ack_i while mem_req_o=0 is ignored.
  - The request stays asserted back-to-back across burst words. Address advances the cycle after each ack.
- No request (read_i=write_i=0) in IDLE: stall_o=0, hit_o=0, no traffic.
- Reset mid-REFILL or mid-WRITE: the line under refill stays invalid (all valids cleared). mem_req_o=0 from the next cycle. A memory transaction already in flight is abandoned, and a late ack is ignored.
- Simultaneous read_i and write_i: treated as write.

Decomposition:
- Package dcache_pkg: state encoding (IDLE/REFILL/WRITE), field offsets/widths derived from parameters (OFFSET_LSB=2, INDEX_LSB=4, TAG_LSB=8), and an address-split helper function.
- One sub-module: dcache_array. It holds the valid/tag/data storage with a combinational lookup port (hit, word) and a synchronous write port (word write, line valid/tag set, global valid clear).

Test Plan:
1. Cold read: reset, read 0x100; memory acks 0x100/0x104/0x108/0x10C with A0..A3 -> stall_o=1 during the 4 acks. The next cycle gives hit_o=1, data_o=A0, stall_o=0.
2. Read hit: then read 0x108 -> same cycle hit_o=1, data_o=A2, mem_req_o stays 0.
3. Write hit with slow memory: write 0x104, data 0xDEADBEEF, ack after 3 cycles -> mem_we_o=1 and address/data stable for 3 cycles, stall_o=0 only in the ack cycle. A following read 0x104 hits with 0xDEADBEEF.
4. Conflict eviction: read 0x1100 (index 0, new tag) -> refill from 0x1100..0x110C. A subsequent read 0x100 misses and refills again.
5. Write miss: write 0x300, data 0x12345678 -> exactly one memory write, no refill. A subsequent read 0x300 misses.
6. Reset mid-refill: read 0x200, reset after 2 acks -> mem_req_o=0 the next cycle and a late ack is ignored. A read 0x200 then issues a full 4-word refill starting at 0x200.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared parameters, FSM encoding and address-split helper for the
// direct-mapped write-through data cache.
package dcache_pkg;

    localparam int INDEX_BITS     = 4;
    localparam int WORDS_PER_LINE = 4;
    localparam int ADDR_W         = 32;
    localparam int DATA_W         = 32;

    localparam int LINES       = 1 << INDEX_BITS;
    localparam int OFFSET_BITS = $clog2(WORDS_PER_LINE);
    localparam int OFFSET_LSB  = 2;
    localparam int INDEX_LSB   = OFFSET_LSB + OFFSET_BITS;
    localparam int TAG_LSB     = INDEX_LSB + INDEX_BITS;
    localparam int TAG_BITS    = ADDR_W - TAG_LSB;

    localparam logic [OFFSET_BITS-1:0] LAST_WORD = OFFSET_BITS'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_WRITE  = 2'd2
    } state_t;

    typedef struct packed {
        logic [TAG_BITS-1:0]    tag;
        logic [INDEX_BITS-1:0]  index;
        logic [OFFSET_BITS-1:0] offset;
    } addr_fields_t;

    function automatic addr_fields_t split_addr(input logic [ADDR_W-1:0] addr);
        addr_fields_t f;
        f.tag    = addr[ADDR_W-1:TAG_LSB];
        f.index  = addr[TAG_LSB-1:INDEX_LSB];
        f.offset = addr[INDEX_LSB-1:OFFSET_LSB];
        return f;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage: combinational lookup port and one synchronous
// write port; a global clear wins over a concurrent valid set.
module dcache_array
    import dcache_pkg::*;
(
    input  logic                   clk,
    input  logic [INDEX_BITS-1:0]  rd_index,
    input  logic [TAG_BITS-1:0]    rd_tag,
    input  logic [OFFSET_BITS-1:0] rd_offset,
    output logic                   rd_hit,
    output logic [DATA_W-1:0]      rd_word,
    input  logic                   wr_en,
    input  logic [INDEX_BITS-1:0]  wr_index,
    input  logic [OFFSET_BITS-1:0] wr_offset,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   set_valid,
    input  logic [TAG_BITS-1:0]    set_tag,
    input  logic                   clear_all
);

    logic [LINES-1:0]    valid;
    logic [TAG_BITS-1:0] tags [LINES];
    logic [DATA_W-1:0]   data [LINES][WORDS_PER_LINE];

    always_ff @(posedge clk) begin
        if (clear_all) begin
            valid <= '0;
        end else if (set_valid) begin
            valid[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (set_valid) begin
            tags[wr_index] <= set_tag;
        end
        if (wr_en) begin
            data[wr_index][wr_offset] <= wr_data;
        end
    end

    assign rd_hit  = valid[rd_index] && (tags[rd_index] == rd_tag);
    assign rd_word = data[rd_index][rd_offset];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller
// below the MEM stage, with 4-word burst refill from backing memory.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | serve read hits combinationally; launch refill or write
// ST_REFILL | fetch the missed line word by word, valid set on last ack
// ST_WRITE  | write one word through; update the cached copy on a hit
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              read_i,
    input  logic              write_i,
    input  logic [ADDR_W-1:0] address_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              hit_o,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
);

    state_t                 state, state_nxt;
    logic [OFFSET_BITS-1:0] count;
    logic [TAG_BITS-1:0]    miss_tag;
    logic [INDEX_BITS-1:0]  miss_index;
    logic [ADDR_W-3:0]      wr_word_addr;
    logic [DATA_W-1:0]      wr_data_q;

    addr_fields_t req_f, lk_f;
    logic              lk_hit;
    logic [DATA_W-1:0] lk_word;

    logic                   arr_wr_en;
    logic [INDEX_BITS-1:0]  arr_wr_index;
    logic [OFFSET_BITS-1:0] arr_wr_offset;
    logic [DATA_W-1:0]      arr_wr_data;
    logic                   arr_set_valid;

    // The single lookup port serves the pipeline in IDLE and the latched
    // store address in WRITE, where the hit decides the cached-copy update.
    assign req_f = split_addr(address_i);
    assign lk_f  = (state == ST_WRITE) ? split_addr({wr_word_addr, 2'b00}) : req_f;

    dcache_array u_array (
        .clk       (clk),
        .rd_index  (lk_f.index),
        .rd_tag    (lk_f.tag),
        .rd_offset (lk_f.offset),
        .rd_hit    (lk_hit),
        .rd_word   (lk_word),
        .wr_en     (arr_wr_en),
        .wr_index  (arr_wr_index),
        .wr_offset (arr_wr_offset),
        .wr_data   (arr_wr_data),
        .set_valid (arr_set_valid),
        .set_tag   (miss_tag),
        .clear_all (reset)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (write_i) begin
                        wr_word_addr <= address_i[ADDR_W-1:2];
                        wr_data_q    <= data_i;
                    end else if (read_i && !lk_hit) begin
                        miss_tag   <= req_f.tag;
                        miss_index <= req_f.index;
                        count      <= '0;
                    end
                end
                ST_REFILL: begin
                    if (mem_ack_i) begin
                        count <= count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt     = state;
        data_o        = '0;
        hit_o         = 1'b0;
        stall_o       = 1'b0;
        mem_req_o     = 1'b0;
        mem_we_o      = 1'b0;
        mem_addr_o    = '0;
        mem_wdata_o   = '0;
        arr_wr_en     = 1'b0;
        arr_wr_index  = miss_index;
        arr_wr_offset = count;
        arr_wr_data   = mem_rdata_i;
        arr_set_valid = 1'b0;

        case (state)
            ST_IDLE: begin
                if (write_i) begin
                    stall_o   = 1'b1;
                    state_nxt = ST_WRITE;
                end else if (read_i) begin
                    if (lk_hit) begin
                        hit_o  = 1'b1;
                        data_o = lk_word;
                    end else begin
                        stall_o   = 1'b1;
                        state_nxt = ST_REFILL;
                    end
                end
            end
            ST_REFILL: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {miss_tag, miss_index, count, 2'b00};
                stall_o    = 1'b1;
                if (mem_ack_i) begin
                    arr_wr_en = 1'b1;
                    if (count == LAST_WORD) begin
                        arr_set_valid = 1'b1;
                        state_nxt     = ST_IDLE;
                    end
                end
            end
            ST_WRITE: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {wr_word_addr, 2'b00};
                mem_wdata_o = wr_data_q;
                stall_o     = !mem_ack_i;
                if (mem_ack_i) begin
                    state_nxt = ST_IDLE;
                    if (lk_hit) begin
                        arr_wr_en     = 1'b1;
                        arr_wr_index  = lk_f.index;
                        arr_wr_offset = lk_f.offset;
                        arr_wr_data   = wr_data_q;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomized scoreboard bench for dcache_ctrl: a line-residency model plus
// a reference memory predict loads and memory transactions.
module tb_dcache_ctrl;

    logic        clk;
    logic        reset;
    logic        read_i, write_i;
    logic [31:0] address_i, data_i;
    logic [31:0] data_o;
    logic        hit_o, stall_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;

    dcache_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .read_i      (read_i),
        .write_i     (write_i),
        .address_i   (address_i),
        .data_i      (data_i),
        .data_o      (data_o),
        .hit_o       (hit_o),
        .stall_o     (stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mtx_t;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_load[$];
    mtx_t        exp_mem[$];

    // reference model: backing memory contents and which tag each line holds
    logic [31:0] ref_mem [int unsigned];
    bit          res_valid [16];
    logic [23:0] res_tag [16];

    // responder's own memory image
    logic [31:0] phys [int unsigned];
    int          fixed_delay = -1;
    int          ack_budget  = -1;
    bit          late_ack    = 1'b0;
    int          acks_seen   = 0;

    function automatic logic [31:0] init_word(input int unsigned widx);
        return (widx * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] addr);
        int unsigned k = addr >> 2;
        return ref_mem.exists(k) ? ref_mem[k] : init_word(k);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // memory responder: acks after 0..3 cycles, or a fixed delay when set
    initial begin
        int  wait_cnt;
        bit  req_seen;
        int unsigned k;
        wait_cnt    = 0;
        req_seen    = 1'b0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req_o && !reset) begin
                if (!req_seen) begin
                    wait_cnt = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
                    req_seen = 1'b1;
                end
                if (wait_cnt == 0 && ack_budget != 0) begin
                    k         = mem_addr_o >> 2;
                    mem_ack_i = 1'b1;
                    if (mem_we_o) begin
                        phys[k]     = mem_wdata_o;
                        mem_rdata_i = $urandom;
                    end else begin
                        mem_rdata_i = phys.exists(k) ? phys[k] : init_word(k);
                    end
                    wait_cnt = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
                    if (ack_budget > 0) ack_budget--;
                end else begin
                    mem_ack_i = 1'b0;
                    if (wait_cnt > 0) wait_cnt--;
                end
            end else begin
                req_seen    = 1'b0;
                mem_ack_i   = late_ack || ($urandom_range(0, 7) == 0);
                mem_rdata_i = $urandom;
            end
        end
    end

    // monitor: pops expectations whenever the DUT completes a load or a memory beat
    bit          prev_pend = 1'b0;
    bit          prev_we;
    logic [31:0] prev_addr, prev_wdata;

    always @(negedge clk) begin
        logic [31:0] el;
        mtx_t        em;
        if (reset) begin
            prev_pend = 1'b0;
        end else begin
            if (read_i && !write_i && !stall_o) begin
                if (exp_load.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL load_unexpected: data_o=%h with no load outstanding", data_o);
                end else begin
                    el = exp_load.pop_front();
                    check("load_data", data_o, el);
                    check("load_hit", {31'd0, hit_o}, 32'd1);
                end
            end
            if (!read_i && !write_i && !mem_req_o) begin
                check("idle_stall", {31'd0, stall_o}, 32'd0);
                check("idle_hit", {31'd0, hit_o}, 32'd0);
                check("idle_data", data_o, 32'd0);
            end
            if (prev_pend && mem_req_o) begin
                check("hold_we", {31'd0, mem_we_o}, {31'd0, prev_we});
                check("hold_addr", mem_addr_o, prev_addr);
                if (prev_we) check("hold_wdata", mem_wdata_o, prev_wdata);
            end
            if (mem_req_o && mem_ack_i) begin
                acks_seen++;
                check("ack_stall", {31'd0, stall_o}, mem_we_o ? 32'd0 : 32'd1);
                if (exp_mem.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL mem_unexpected: we=%0d addr=%h with no transaction expected", mem_we_o, mem_addr_o);
                end else begin
                    em = exp_mem.pop_front();
                    check("mem_we", {31'd0, mem_we_o}, {31'd0, em.we});
                    check("mem_addr", mem_addr_o, em.addr);
                    if (em.we) check("mem_wdata", mem_wdata_o, em.wdata);
                end
            end else if (mem_req_o) begin
                check("pend_stall", {31'd0, stall_o}, 32'd1);
            end
            prev_pend  = mem_req_o && !mem_ack_i;
            prev_we    = mem_we_o;
            prev_addr  = mem_addr_o;
            prev_wdata = mem_wdata_o;
        end
    end

    task automatic apply_reset();
        @(posedge clk);
        #1;
        reset   = 1'b1;
        read_i  = 1'b0;
        write_i = 1'b0;
        exp_load.delete();
        exp_mem.delete();
        for (int i = 0; i < 16; i++) res_valid[i] = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic do_access(input bit wr, input bit rd, input logic [31:0] addr,
                             input logic [31:0] wdata, output int stalls);
        int          idx;
        logic [23:0] tg;
        bit          pred_hit;
        int          n;
        idx      = int'(addr[7:4]);
        tg       = addr[31:8];
        pred_hit = 1'b0;
        if (wr) begin
            exp_mem.push_back('{1'b1, {addr[31:2], 2'b00}, wdata});
            ref_mem[addr >> 2] = wdata;
        end else if (rd) begin
            pred_hit = res_valid[idx] && (res_tag[idx] == tg);
            if (!pred_hit) begin
                for (int w = 0; w < 4; w++)
                    exp_mem.push_back('{1'b0, {addr[31:4], 4'b0000} + 32'(w * 4), 32'd0});
                res_valid[idx] = 1'b1;
                res_tag[idx]   = tg;
            end
            exp_load.push_back(ref_word(addr));
        end
        @(posedge clk);
        #1;
        write_i   = wr;
        read_i    = rd;
        address_i = addr;
        data_i    = wdata;
        stalls    = 0;
        n         = 0;
        forever begin
            @(negedge clk);
            if (!stall_o) break;
            stalls++;
            n++;
            if (n > 200) begin
                tests++;
                fails++;
                $display("FAIL stall_timeout: addr=%h still stalled after %0d cycles", addr, n);
                break;
            end
        end
        if (rd && !wr) check("read_latency_hit", {31'd0, stalls == 0}, {31'd0, pred_hit});
    endtask

    task automatic go_idle();
        @(posedge clk);
        #1;
        read_i  = 1'b0;
        write_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int base;
        int n;
        logic [31:0] addr;
        logic [23:0] tg;
        reset     = 1'b1;
        read_i    = 1'b0;
        write_i   = 1'b0;
        address_i = '0;
        data_i    = '0;
        for (int i = 0; i < 16; i++) res_valid[i] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        @(negedge clk);
        check("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we_o}, 32'd0);
        check("rst_mem_addr", mem_addr_o, 32'd0);
        check("rst_mem_wdata", mem_wdata_o, 32'd0);
        check("rst_stall", {31'd0, stall_o}, 32'd0);
        check("rst_hit", {31'd0, hit_o}, 32'd0);
        check("rst_data", data_o, 32'd0);

        // cold miss, then hit on the same line
        do_access(1'b0, 1'b1, 32'h100, 32'd0, st);
        do_access(1'b0, 1'b1, 32'h108, 32'd0, st);
        check("hit_no_req", {31'd0, mem_req_o}, 32'd0);
        go_idle();

        // write hit against slow memory, then read it back
        fixed_delay = 3;
        do_access(1'b1, 1'b0, 32'h104, 32'hDEAD_BEEF, st);
        check("write_slow_stalls", st, 32'd4);
        fixed_delay = -1;
        do_access(1'b0, 1'b1, 32'h104, 32'd0, st);
        go_idle();

        // conflict eviction on index 0
        do_access(1'b0, 1'b1, 32'h1100, 32'd0, st);
        do_access(1'b0, 1'b1, 32'h100, 32'd0, st);
        go_idle();

        // write miss allocates nothing
        do_access(1'b1, 1'b0, 32'h300, 32'h1234_5678, st);
        do_access(1'b0, 1'b1, 32'h300, 32'd0, st);
        go_idle();

        // reset in the middle of a refill
        apply_reset();
        ack_budget = 2;
        exp_mem.push_back('{1'b0, 32'h200, 32'd0});
        exp_mem.push_back('{1'b0, 32'h204, 32'd0});
        base = acks_seen;
        @(posedge clk);
        #1;
        read_i    = 1'b1;
        address_i = 32'h200;
        n = 0;
        while (acks_seen < base + 2 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("midrefill_acks", acks_seen - base, 32'd2);
        apply_reset();
        @(negedge clk);
        check("midrefill_req_off", {31'd0, mem_req_o}, 32'd0);
        late_ack = 1'b1;
        @(negedge clk);
        check("late_ack_req", {31'd0, mem_req_o}, 32'd0);
        check("late_ack_stall", {31'd0, stall_o}, 32'd0);
        late_ack = 1'b0;
        @(negedge clk);
        check("late_ack_after", {31'd0, mem_req_o}, 32'd0);
        ack_budget = -1;
        do_access(1'b0, 1'b1, 32'h200, 32'd0, st);
        go_idle();

        // randomized traffic over a few tags to force hits, misses and conflicts
        for (int i = 0; i < 250; i++) begin
            bit wr, rd;
            tg   = ($urandom_range(0, 9) == 0) ? 24'($urandom) : 24'($urandom_range(0, 2));
            addr = {tg, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            wr   = ($urandom_range(0, 9) < 3);
            rd   = wr ? ($urandom_range(0, 1) == 1) : 1'b1;
            do_access(wr, rd, addr, $urandom, st);
            if ($urandom_range(0, 3) == 0) go_idle();
        end
        go_idle();

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("load_queue_drained", exp_load.size(), 32'd0);
        check("mem_queue_drained", exp_mem.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
